// File: rtl/arcade_input_conditioner.sv
// Per-player arcade control conditioner between the joystick/keyboard decode and the core's input
// registers: debounce, rotated-control remap, SOCD cleaning, per-button autofire and queued coin pulses.
module arcade_input_conditioner #(
    parameter int NPLAYERS    = 2,
    parameter int NBUTTONS    = 6,
    parameter int DEB_CYCLES  = 24000,
    parameter int COIN_CYCLES = 2400000,
    parameter int AF_FRAMES   = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic [NPLAYERS*(4+NBUTTONS)-1:0] joy_in,
    input  logic [NPLAYERS-1:0]              coin_in,
    input  logic [NPLAYERS-1:0]              start_in,
    input  logic                             rotate,
    input  logic                             rot_ccw,
    input  logic [NBUTTONS-1:0]              af_en,
    input  logic                             vblank,
    output logic [NPLAYERS*(4+NBUTTONS)-1:0] joy_out,
    output logic [NPLAYERS-1:0]              coin_out,
    output logic [NPLAYERS-1:0]              start_out
);
    localparam int PW     = 4 + NBUTTONS;
    localparam int JW     = NPLAYERS * PW;
    localparam int NRAW   = JW + 2 * NPLAYERS;
    localparam int NAF    = NPLAYERS * NBUTTONS;
    localparam int PRE_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int COIN_W = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
    localparam int AF_W   = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DEB_CYCLES - 1);
    localparam logic [COIN_W-1:0] COIN_LAST = COIN_W'(COIN_CYCLES - 1);
    localparam logic [AF_W-1:0]   AF_LAST   = AF_W'(AF_FRAMES - 1);
    localparam logic              POL       = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        COIN_IDLE = 2'd0,
        COIN_HIGH = 2'd1,
        COIN_GAP  = 2'd2
    } coin_state_e;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick_s;
    logic [NRAW-1:0]     raw_s, agree_s, samp_q, samp_d, stab_q, stab_d;
    logic [JW-1:0]       joy_db_s;
    logic [NPLAYERS-1:0] coin_db_s, start_db_s;
    logic                vb_q, vb_d, vb_rise_s;
    logic [NAF-1:0]      btn_db_s, af_phase_q, af_phase_d;
    logic [AF_W-1:0]     af_cnt_q [NAF];
    logic [AF_W-1:0]     af_cnt_d [NAF];
    logic [JW-1:0]       joy_cond_s, joy_out_q, joy_out_d;
    logic [NPLAYERS-1:0] start_out_q, start_out_d, coin_out_s;

    assign raw_s      = {start_in, coin_in, joy_in};
    assign joy_db_s   = stab_q[JW-1:0];
    assign coin_db_s  = stab_q[JW +: NPLAYERS];
    assign start_db_s = stab_q[JW+NPLAYERS +: NPLAYERS];

    // Prescaler, two-sample debounce (a bit moves only when two ticks agree) and vblank edge detect
    always_comb begin
        tick_s    = (pre_q == PRE_LAST);
        agree_s   = ~(raw_s ^ samp_q);
        vb_d      = vblank;
        vb_rise_s = vblank & ~vb_q;
        if (tick_s) begin
            pre_d  = {PRE_W{1'b0}};
            samp_d = raw_s;
            stab_d = (raw_s & agree_s) | (stab_q & ~agree_s);
        end else begin
            pre_d  = pre_q + PRE_W'(1);
            samp_d = samp_q;
            stab_d = stab_q;
        end
    end

    // Autofire phase: starts asserted on press, flips every AF_FRAMES-th vblank edge while held
    always_comb begin
        af_phase_d = af_phase_q;
        af_cnt_d   = af_cnt_q;
        for (int i = 0; i < NAF; i++) begin
            if (!btn_db_s[i]) begin
                af_phase_d[i] = 1'b1;
                af_cnt_d[i]   = {AF_W{1'b0}};
            end else if (vb_rise_s) begin
                if (af_cnt_q[i] == AF_LAST) begin
                    af_phase_d[i] = ~af_phase_q[i];
                    af_cnt_d[i]   = {AF_W{1'b0}};
                end else begin
                    af_cnt_d[i] = af_cnt_q[i] + AF_W'(1);
                end
            end else begin
                af_cnt_d[i] = af_cnt_q[i];
            end
        end
    end

    // Output polarity applied before the output register
    always_comb begin
        joy_out_d   = joy_cond_s ^ {JW{POL}};
        start_out_d = start_db_s ^ {NPLAYERS{POL}};
    end

    // Shared conditioning state and registered joystick/start outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_q       <= {PRE_W{1'b0}};
            samp_q      <= {NRAW{1'b0}};
            stab_q      <= {NRAW{1'b0}};
            vb_q        <= 1'b0;
            af_phase_q  <= {NAF{1'b1}};
            joy_out_q   <= {JW{POL}};
            start_out_q <= {NPLAYERS{POL}};
            for (int i = 0; i < NAF; i++) begin
                af_cnt_q[i] <= {AF_W{1'b0}};
            end
        end else begin
            pre_q       <= pre_d;
            samp_q      <= samp_d;
            stab_q      <= stab_d;
            vb_q        <= vb_d;
            af_phase_q  <= af_phase_d;
            joy_out_q   <= joy_out_d;
            start_out_q <= start_out_d;
            for (int i = 0; i < NAF; i++) begin
                af_cnt_q[i] <= af_cnt_d[i];
            end
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        logic [3:0]          dir_db_s, dir_rot_s, dir_clean_s;
        logic [NBUTTONS-1:0] btn_s;
        coin_state_e         state_q;
        logic [COIN_W-1:0]   cnt_q;
        logic [1:0]          queue_q;
        logic                prev_q, pulse_q;
        logic                rise_s, last_s, inc_s, dec_s;

        assign dir_db_s                         = joy_db_s[p*PW +: 4];
        assign btn_db_s[p*NBUTTONS +: NBUTTONS] = joy_db_s[p*PW+4 +: NBUTTONS];

        // Direction word is {up,down,left,right}; rotate, then cancel opposing pairs
        always_comb begin
            if (!rotate) begin
                dir_rot_s = dir_db_s;
            end else if (!rot_ccw) begin
                dir_rot_s = {dir_db_s[0], dir_db_s[1], dir_db_s[3], dir_db_s[2]};
            end else begin
                dir_rot_s = {dir_db_s[1], dir_db_s[0], dir_db_s[2], dir_db_s[3]};
            end
            if (dir_rot_s[3] & dir_rot_s[2]) begin
                dir_clean_s[3:2] = 2'b00;
            end else begin
                dir_clean_s[3:2] = dir_rot_s[3:2];
            end
            if (dir_rot_s[1] & dir_rot_s[0]) begin
                dir_clean_s[1:0] = 2'b00;
            end else begin
                dir_clean_s[1:0] = dir_rot_s[1:0];
            end
            btn_s = btn_db_s[p*NBUTTONS +: NBUTTONS] & (~af_en | af_phase_q[p*NBUTTONS +: NBUTTONS]);
        end

        assign joy_cond_s[p*PW +: PW] = {btn_s, dir_clean_s};
        assign rise_s                 = coin_db_s[p] & ~prev_q;
        assign last_s                 = (cnt_q == COIN_LAST);

        // A coin arriving while a pulse is owed is queued; a pending coin is consumed on each new pulse
        always_comb begin
            inc_s = rise_s & ((state_q != COIN_IDLE) | (queue_q != 2'd0));
            dec_s = (queue_q != 2'd0) & ((state_q == COIN_IDLE) | ((state_q == COIN_GAP) & last_s));
        end

        // Coin pulse FSM: fixed high time followed by a fixed low gap
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state_q <= COIN_IDLE;
                cnt_q   <= {COIN_W{1'b0}};
                queue_q <= 2'd0;
                prev_q  <= 1'b0;
                pulse_q <= POL;
            end else begin
                prev_q <= coin_db_s[p];
                if (inc_s && !dec_s && (queue_q != 2'd3)) begin
                    queue_q <= queue_q + 2'd1;
                end else if (dec_s && !inc_s) begin
                    queue_q <= queue_q - 2'd1;
                end else begin
                    queue_q <= queue_q;
                end
                case (state_q)
                    COIN_IDLE: begin
                        if (rise_s || (queue_q != 2'd0)) begin
                            state_q <= COIN_HIGH;
                            pulse_q <= ~POL;
                        end
                        cnt_q <= {COIN_W{1'b0}};
                    end
                    COIN_HIGH: begin
                        if (last_s) begin
                            state_q <= COIN_GAP;
                            pulse_q <= POL;
                            cnt_q   <= {COIN_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + COIN_W'(1);
                        end
                    end
                    COIN_GAP: begin
                        if (last_s) begin
                            if (queue_q != 2'd0) begin
                                state_q <= COIN_HIGH;
                                pulse_q <= ~POL;
                            end else begin
                                state_q <= COIN_IDLE;
                            end
                            cnt_q <= {COIN_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + COIN_W'(1);
                        end
                    end
                    default: begin
                        state_q <= COIN_IDLE;
                        pulse_q <= POL;
                        cnt_q   <= {COIN_W{1'b0}};
                    end
                endcase
            end
        end

        assign coin_out_s[p] = pulse_q;
    end

    assign joy_out   = joy_out_q;
    assign start_out = start_out_q;
    assign coin_out  = coin_out_s;

endmodule
